// File: rtl/btb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | btb_ctrl : BTB RAM port arbiter - clear sweep, 2-entry update queue, fwd     |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module btb_ctrl #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush_start,
  input  logic        i_lkp_valid,
  input  logic [9:0]  i_lkp_addr,
  input  logic        i_upd_valid,
  input  logic [9:0]  i_upd_addr,
  input  logic [31:0] i_upd_data,
  output logic        o_upd_ready,
  output logic        o_lkp_grant,
  output logic        o_fwd_hit,
  output logic [31:0] o_fwd_data,
  output logic        o_btb_wren,
  output logic [9:0]  o_btb_addr,
  output logic [31:0] o_btb_data,
  output logic        o_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {RST_WAIT = 2'd0, INIT = 2'd1, RUN = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [9:0]     sweep_q, sweep_d;
  logic [1:0]     count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [9:0]     qaddr_q [2];
  logic [9:0]     qaddr_d [2];
  logic [31:0]    qdata_q [2];
  logic [31:0]    qdata_d [2];

  logic flush, push, drain;

  // A flush cycle never drains: the queued updates are about to be discarded.
  always_comb begin
    flush       = (state_q == RUN) && i_flush_start;
    o_upd_ready = (state_q == RUN) && (count_q < 2'(QDEPTH));
    push        = i_upd_valid && o_upd_ready;
    drain       = (state_q == RUN) && !flush && (count_q != 2'd0) &&
                  (!i_lkp_valid || (count_q == 2'(QDEPTH)) ||
                   (starve_q == SW'(STARVE_MAX)));
  end

  // Slot 0 is always the head; a pop shifts slot 1 down before any push lands.
  always_comb begin
    qaddr_d = qaddr_q;
    qdata_d = qdata_q;
    count_d = count_q;
    if (drain) begin
      qaddr_d[0] = qaddr_q[1];
      qdata_d[0] = qdata_q[1];
      count_d    = count_q - 2'd1;
    end
    if (push) begin
      qaddr_d[count_d[0]] = i_upd_addr;
      qdata_d[count_d[0]] = i_upd_data;
      count_d             = count_d + 2'd1;
    end
    if (flush) begin
      count_d = 2'd0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if ((state_q != RUN) || flush || (count_q == 2'd0) || drain) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    o_btb_wren  = 1'b0;
    o_btb_addr  = 10'd0;
    o_btb_data  = 32'd0;
    o_lkp_grant = 1'b0;
    o_busy      = 1'b1;
    case (state_q)
      RST_WAIT: begin
        state_d = INIT;
        sweep_d = 10'd0;
      end
      INIT: begin
        o_btb_wren = 1'b1;
        o_btb_addr = sweep_q;
        sweep_d    = sweep_q + 10'd1;
        if (sweep_q == 10'h3FF) begin
          state_d = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b0;
        if (drain) begin
          o_btb_wren = 1'b1;
          o_btb_addr = qaddr_q[0];
          o_btb_data = qdata_q[0];
        end else begin
          o_btb_addr  = i_lkp_addr;
          o_lkp_grant = i_lkp_valid;
        end
        if (flush) begin
          state_d = INIT;
          sweep_d = 10'd0;
        end
      end
      default: begin
        state_d = RST_WAIT;
      end
    endcase
  end

  // Youngest valid match wins, so slot 1 is checked first.
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = 32'd0;
    if ((count_q == 2'd2) && (qaddr_q[1] == i_lkp_addr)) begin
      o_fwd_hit  = 1'b1;
      o_fwd_data = qdata_q[1];
    end else if ((count_q != 2'd0) && (qaddr_q[0] == i_lkp_addr)) begin
      o_fwd_hit  = 1'b1;
      o_fwd_data = qdata_q[0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= RST_WAIT;
      sweep_q    <= 10'd0;
      count_q    <= 2'd0;
      starve_q   <= '0;
      qaddr_q[0] <= 10'd0;
      qaddr_q[1] <= 10'd0;
      qdata_q[0] <= 32'd0;
      qdata_q[1] <= 32'd0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      qaddr_q[0] <= qaddr_d[0];
      qaddr_q[1] <= qaddr_d[1];
      qdata_q[0] <= qdata_d[0];
      qdata_q[1] <= qdata_d[1];
    end
  end

endmodule
`default_nettype wire

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 Parameter: QDEPTH, 2, update-queue depth in entries (fixed at 2 for this revision).
REQ-002 Parameter: STARVE_MAX, 4, consecutive cycles a queued update may wait before forced drain.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_flush_start  in  1  request full-table clear; honoured only in RUN.
REQ-006 i_lkp_valid  in  1  fetch-stage lookup request this cycle.
REQ-007 i_lkp_addr  in  10  fetch lookup index.
REQ-008 i_upd_valid  in  1  EX-stage update request.
REQ-009 i_upd_addr  in  10  update index.
REQ-010 i_upd_data  in  32  update target/tag word.
REQ-011 o_upd_ready  out  1  update accepted when i_upd_valid & o_upd_ready.
REQ-012 o_lkp_grant  out  1  RAM port drives i_lkp_addr this cycle; RAM read data valid after falling edge of same cycle.
REQ-013 o_fwd_hit  out  1  i_lkp_addr matches a pending queued update.
REQ-014 o_fwd_data  out  32  data of youngest matching queued update; 0 when no hit.
REQ-015 o_btb_wren  out  1  RAM write enable.
REQ-016 o_btb_addr  out  10  RAM address.
REQ-017 o_btb_data  out  32  RAM write data.
REQ-018 o_busy  out  1  table clear in progress.

Function
REQ-019 FSM states: RST_WAIT, INIT, RUN; RST_WAIT -> INIT after one cycle; INIT -> RUN after writing index 1023; RUN -> INIT on i_flush_start.
REQ-020 RST_WAIT: o_btb_wren=0, o_btb_addr=0, o_btb_data=0, o_lkp_grant=0, o_upd_ready=0, o_busy=1.
REQ-021 INIT: one write per cycle, o_btb_wren=1, o_btb_data=0, o_btb_addr = 10-bit sweep counter starting at 0, +1 per cycle; 1024 cycles total; o_busy=1, o_lkp_grant=0, o_upd_ready=0.
REQ-022 Entering INIT from RUN clears the update queue and starve counter; accepted-but-undrained updates are discarded.
REQ-023 RUN: o_busy=0; o_upd_ready = (queue count < QDEPTH), combinational, independent of same-cycle drain.
REQ-024 Queue is FIFO; push on i_upd_valid & o_upd_ready; push and drain in same cycle both take effect.
REQ-025 Drain granted in RUN when queue non-empty and (!i_lkp_valid or count==QDEPTH or starve counter==STARVE_MAX).
REQ-026 Drain cycle: o_btb_wren=1, o_btb_addr/o_btb_data = head entry, o_lkp_grant=0, head popped at clock edge.
REQ-027 Non-drain cycle in RUN: o_btb_wren=0, o_btb_addr=i_lkp_addr, o_btb_data=0, o_lkp_grant=i_lkp_valid.
REQ-028 Minimum update latency: accepted at edge N -> RAM write in cycle N+1 (queue never bypassed).
REQ-029 Starve counter: +1 each RUN cycle queue non-empty and no drain, saturating at STARVE_MAX; cleared on drain or empty queue.
REQ-030 Forwarding: combinational compare of i_lkp_addr against all valid entries; youngest match wins; evaluated in all states, valid entries only.
REQ-031 Queue outputs o_fwd_hit=0, o_fwd_data=0 when queue empty.

Reset
REQ-032 i_reset low asynchronously forces RST_WAIT, sweep counter 0, queue empty, starve counter 0; outputs per REQ-020.
REQ-033 Reset asserted mid-INIT or mid-RUN aborts sweep/queue; after release full 1024-cycle sweep restarts from index 0.

Verification
REQ-034 Release reset -> 1 cycle wren=0, then 1024 cycles wren=1 addr 0..1023 data 0, o_busy falls first RUN cycle, o_upd_ready=1.
REQ-035 RUN, no lookup, update addr 0x005 data 0x0000_1234 accepted at edge N -> cycle N+1 wren=1 addr 0x005 data 0x0000_1234.
REQ-036 Lookup valid every cycle, two updates back-to-back -> count=2, o_upd_ready=0, next cycle drain wins, o_lkp_grant=0.
REQ-037 Lookup valid every cycle, one update queued -> drain occurs after 4 waiting cycles, lookups granted during wait.
REQ-038 Queue holds addr 0x010 data 0xA then addr 0x010 data 0xB, lookup 0x010 -> o_fwd_hit=1, o_fwd_data=0xB; lookup 0x011 -> o_fwd_hit=0.
REQ-039 i_flush_start with 2 queued -> queue empty, 1024-cycle sweep, no queued write issued; reset at sweep index 500 -> RST_WAIT, sweep restarts at 0.
